// File: rtl/accel_avg_filter.sv
// Per-axis boxcar average of the accelerometer X/Y/Z samples.
// One shared adder updates the three running sums, one axis per cycle.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | waiting for data_update; samples latched on acceptance
//  ST_SX   | X sum updated, X sample written into its window
//  ST_SY   | Y sum updated, Y sample written into its window
//  ST_SZ   | Z sum updated; pointer/fill advance, averages published
module accel_avg_filter #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              data_update,
    input  logic [DATA_W-1:0] data_x,
    input  logic [DATA_W-1:0] data_y,
    input  logic [DATA_W-1:0] data_z,
    output logic [DATA_W-1:0] avg_x,
    output logic [DATA_W-1:0] avg_y,
    output logic [DATA_W-1:0] avg_z,
    output logic              avg_valid,
    output logic              filled,
    output logic              overrun,
    output logic [7:0]        drop_count
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SX   = 2'd1;
    localparam logic [1:0] ST_SY   = 2'd2;
    localparam logic [1:0] ST_SZ   = 2'd3;

    localparam logic [AVG_LOG2-1:0] PTR_ONE  = AVG_LOG2'(1);
    localparam logic [AVG_LOG2:0]   CNT_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2:0]   FILL_MAX = {1'b1, {AVG_LOG2{1'b0}}};

    logic [1:0]          state;
    logic                flush;
    logic                drop_now;

    logic [DATA_W-1:0]   lat_x;
    logic [DATA_W-1:0]   lat_y;
    logic [DATA_W-1:0]   lat_z;

    logic [DATA_W-1:0]   buf_x [DEPTH];
    logic [DATA_W-1:0]   buf_y [DEPTH];
    logic [DATA_W-1:0]   buf_z [DEPTH];

    logic [SUM_W-1:0]    sum_x;
    logic [SUM_W-1:0]    sum_y;
    logic [SUM_W-1:0]    sum_z;

    logic [AVG_LOG2-1:0] wptr;
    logic [AVG_LOG2:0]   fill_cnt;

    logic [SUM_W-1:0]    add_sum;
    logic [DATA_W-1:0]   add_old;
    logic [DATA_W-1:0]   add_new;
    logic [SUM_W-1:0]    add_res;

    function automatic logic [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{AVG_LOG2{v[DATA_W-1]}}, v};
    endfunction

    assign flush    = rst | clear;
    assign drop_now = data_update && (state != ST_IDLE);
    assign filled   = (fill_cnt == FILL_MAX);

    // Operand select for the shared adder; the axis follows the state.
    always_comb begin
        add_sum = sum_x;
        add_old = buf_x[wptr];
        add_new = lat_x;
        case (state)
            ST_SY: begin
                add_sum = sum_y;
                add_old = buf_y[wptr];
                add_new = lat_y;
            end
            ST_SZ: begin
                add_sum = sum_z;
                add_old = buf_z[wptr];
                add_new = lat_z;
            end
            default: ;
        endcase
    end

    // Two's-complement modular arithmetic: the window bound keeps the sum in range.
    assign add_res = add_sum - sext(add_old) + sext(add_new);

    always_ff @(posedge clk) begin
        if (flush) begin
            state <= ST_IDLE;
            lat_x <= '0;
            lat_y <= '0;
            lat_z <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_update) begin
                        lat_x <= data_x;
                        lat_y <= data_y;
                        lat_z <= data_z;
                        state <= ST_SX;
                    end
                end
                ST_SX:   state <= ST_SY;
                ST_SY:   state <= ST_SZ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            sum_x <= '0;
            sum_y <= '0;
            sum_z <= '0;
        end else begin
            case (state)
                ST_SX:   sum_x <= add_res;
                ST_SY:   sum_y <= add_res;
                ST_SZ:   sum_z <= add_res;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_x[i] <= '0;
                buf_y[i] <= '0;
                buf_z[i] <= '0;
            end
        end else begin
            case (state)
                ST_SX:   buf_x[wptr] <= lat_x;
                ST_SY:   buf_y[wptr] <= lat_y;
                ST_SZ:   buf_z[wptr] <= lat_z;
                default: ;
            endcase
        end
    end

    // Z is still being summed in ST_SZ, so its average comes straight off the adder.
    always_ff @(posedge clk) begin
        if (flush) begin
            wptr      <= '0;
            fill_cnt  <= '0;
            avg_x     <= '0;
            avg_y     <= '0;
            avg_z     <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (state == ST_SZ) begin
                wptr      <= wptr + PTR_ONE;
                if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + CNT_ONE;
                end
                avg_x     <= sum_x[SUM_W-1:AVG_LOG2];
                avg_y     <= sum_y[SUM_W-1:AVG_LOG2];
                avg_z     <= add_res[SUM_W-1:AVG_LOG2];
                avg_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            drop_count <= 8'd0;
        end else if (clear) begin
            overrun    <= 1'b0;
        end else begin
            overrun <= drop_now;
            if (drop_now && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_accel_avg_filter.sv
// Randomised scoreboard bench for accel_avg_filter: a window-queue reference model
// predicts each average and each drop; a negedge monitor pops and compares.
module tb_accel_avg_filter;

    localparam int DATA_W   = 16;
    localparam int AVG_LOG2 = 3;
    localparam int N        = 1 << AVG_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              data_update;
    logic [DATA_W-1:0] data_x;
    logic [DATA_W-1:0] data_y;
    logic [DATA_W-1:0] data_z;
    logic [DATA_W-1:0] avg_x;
    logic [DATA_W-1:0] avg_y;
    logic [DATA_W-1:0] avg_z;
    logic              avg_valid;
    logic              filled;
    logic              overrun;
    logic [7:0]        drop_count;

    accel_avg_filter #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .data_update (data_update),
        .data_x      (data_x),
        .data_y      (data_y),
        .data_z      (data_z),
        .avg_x       (avg_x),
        .avg_y       (avg_y),
        .avg_z       (avg_z),
        .avg_valid   (avg_valid),
        .filled      (filled),
        .overrun     (overrun),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef int iq_t[$];
    typedef struct { int e; int x; int y; int z; int f; } exp_t;
    typedef struct { int e; int c; } drop_t;

    exp_t  sb_q[$];
    drop_t drop_q[$];
    iq_t   win_x, win_y, win_z;
    int    fill_m;
    int    drop_m;
    int    last_acc;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sx(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int win_avg(input iq_t q);
        int s = 0;
        foreach (q[i]) s += q[i];
        return floor_div(s);
    endfunction

    task automatic model_reset(input bit is_rst);
        // An accepted update whose Z step has not yet completed is lost.
        if (edge_n <= last_acc + 3) void'(sb_q.pop_back());
        win_x.delete(); win_y.delete(); win_z.delete();
        for (int i = 0; i < N; i++) begin
            win_x.push_back(0); win_y.push_back(0); win_z.push_back(0);
        end
        fill_m   = 0;
        last_acc = -100;
        if (is_rst) drop_m = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int x, input int y, input int z);
        exp_t  e;
        drop_t d;
        data_x = DATA_W'(x);
        data_y = DATA_W'(y);
        data_z = DATA_W'(z);
        data_update = 1'b1;
        tick();
        data_update = 1'b0;
        if (edge_n >= last_acc + 4) begin
            last_acc = edge_n;
            win_x.push_back(x); void'(win_x.pop_front());
            win_y.push_back(y); void'(win_y.pop_front());
            win_z.push_back(z); void'(win_z.pop_front());
            if (fill_m < N) fill_m++;
            e.e = edge_n + 3;
            e.x = win_avg(win_x);
            e.y = win_avg(win_y);
            e.z = win_avg(win_z);
            e.f = (fill_m == N) ? 1 : 0;
            sb_q.push_back(e);
        end else begin
            if (drop_m < 255) drop_m++;
            d.e = edge_n;
            d.c = drop_m;
            drop_q.push_back(d);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_reset(1'b0);
    endtask

    task automatic do_rst_with_update(input int x);
        rst = 1'b1;
        data_x = DATA_W'(x);
        data_update = 1'b1;
        tick();
        rst = 1'b0;
        data_update = 1'b0;
        model_reset(1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_avg_x"}, sx(avg_x), 0);
        check({tag, "_avg_y"}, sx(avg_y), 0);
        check({tag, "_avg_z"}, sx(avg_z), 0);
        check({tag, "_avg_valid"}, int'(avg_valid), 0);
        check({tag, "_filled"}, int'(filled), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    function automatic int rand_sample();
        logic [DATA_W-1:0] r;
        if ($urandom_range(0, 3) == 0) begin
            r = DATA_W'($urandom);
            return int'($signed(r));
        end
        return int'($urandom_range(0, 600)) - 300;
    endfunction

    exp_t  mon_e;
    drop_t mon_d;
    always @(negedge clk) begin
        if (avg_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_avg_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("valid_cycle", edge_n, mon_e.e);
                check("avg_x", sx(avg_x), mon_e.x);
                check("avg_y", sx(avg_y), mon_e.y);
                check("avg_z", sx(avg_z), mon_e.z);
                check("filled", int'(filled), mon_e.f);
            end
        end
        if (overrun === 1'b1) begin
            if (drop_q.size() == 0) begin
                check("unexpected_overrun", 1, 0);
            end else begin
                mon_d = drop_q.pop_front();
                check("overrun_cycle", edge_n, mon_d.e);
                check("drop_count", int'(drop_count), mon_d.c);
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; data_update = 1'b0;
        data_x = '0; data_y = '0; data_z = '0;
        last_acc = -100;
        drop_m = 0;
        model_reset(1'b1);
        idle(3);
        rst = 1'b0;
        check_zero_outputs("reset");
        check("reset_drop_count", int'(drop_count), 0);

        // Ramp from an empty window, then wrap with the opposite sign.
        for (int i = 0; i < N; i++) begin send(100, 0, -3); idle(9); end
        check("ramp_avg_x", sx(avg_x), 100);
        check("ramp_avg_z", sx(avg_z), -3);
        check("ramp_filled", int'(filled), 1);
        for (int i = 0; i < N; i++) begin send(-100, 0, -3); idle(9); end
        check("wrap_avg_x", sx(avg_x), -100);

        // Back-to-back update two edges later is dropped.
        send(5, 6, 7);
        idle(1);
        send(1, 1, 1);
        idle(8);
        check("b2b_drop_count", int'(drop_count), 1);

        for (int i = 0; i < N; i++) begin send(-32768, 0, 0); idle(5); end
        check("min_avg_x", sx(avg_x), -32768);
        for (int i = 0; i < N; i++) begin send(32767, 32767, 32767); idle(5); end
        check("max_avg_x", sx(avg_x), 32767);
        check("max_avg_z", sx(avg_z), 32767);

        // clear two edges into a sequence.
        send(10, 20, 30);
        idle(1);
        do_clear();
        check_zero_outputs("clear");
        check("clear_drop_count", int'(drop_count), 1);
        idle(6);
        for (int i = 0; i < N; i++) begin send(100, 0, -3); idle(9); end
        check("clear_ramp_avg_x", sx(avg_x), 100);

        // rst mid-sequence with a coincident update.
        send(1, 2, 3);
        idle(1);
        do_rst_with_update(77);
        check_zero_outputs("rst");
        check("rst_drop_count", int'(drop_count), 0);
        idle(6);
        check("rst_no_drop", int'(drop_count), 0);

        repeat (300) begin
            send(rand_sample(), rand_sample(), rand_sample());
            idle($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) do_clear();
        end
        idle(10);

        check("sb_drained", sb_q.size(), 0);
        check("drops_drained", drop_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
